kb_code_receiver: RTL and testbench



---
 rtl/kb_code_receiver_pkg.sv | 6 +
 rtl/kb_code_receiver_if.sv | 11 +
 rtl/kb_code_receiver_strobe_sync.sv | 27 ++
 rtl/kb_code_receiver.sv | 79 +++++++
 tb/tb_kb_code_receiver.sv | 125 ++++++++++++
 5 files changed

// File: rtl/kb_code_receiver_pkg.sv
// alarm_pkg: shared key-result and alarm-state encodings plus symbol width
package alarm_pkg;
  localparam int SYM_W = 2;
  typedef enum logic [1:0] {KEY_OK = 2'd0, KEY_OKNEG = 2'd1, KEY_ERROR = 2'd2, NO_KEY = 2'd3} key_result_t;
  typedef enum logic [1:0] {INACTIVO = 2'd0, ARMADO = 2'd1, ESPERA = 2'd2, ALARMA = 2'd3} alarm_state_t;
endpackage

// File: rtl/kb_code_receiver_if.sv
// kb_code_receiver_if: keypad strobe/data, reference KEY in; RESULT, BUSY, LOCKED out
interface kb_code_receiver_if #(parameter int CODE_LEN = 4);
  logic                  KB_RECV;
  logic [1:0]            KB_IN;
  logic [2*CODE_LEN-1:0] KEY;
  logic [1:0]            RESULT;
  logic                  BUSY;
  logic                  LOCKED;
  modport master (output KB_RECV, KB_IN, KEY, input RESULT, BUSY, LOCKED);
  modport slave (input KB_RECV, KB_IN, KEY, output RESULT, BUSY, LOCKED);
endinterface

// File: rtl/kb_code_receiver_strobe_sync.sv
// kb_strobe_sync: 2-FF sync of kb_recv/kb_in, sym_valid pulses on synced kb_recv rise with sym
module kb_strobe_sync
  import alarm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             kb_recv,
  input  logic [SYM_W-1:0] kb_in,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym
);
  logic [2:0]       recv_q;
  logic [SYM_W-1:0] in_q1, in_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      recv_q <= '0;
      in_q1  <= '0;
      in_q2  <= '0;
    end else begin
      recv_q <= {recv_q[1:0], kb_recv};
      in_q1  <= kb_in;
      in_q2  <= in_q1;
    end
  end
  assign sym_valid = recv_q[1] & ~recv_q[2];
  assign sym       = in_q2;
endmodule

// File: rtl/kb_code_receiver.sv
// kb_code_receiver: CLK/RST plus kb slave port; assembles keypad code, checks KEY, pulses RESULT, locks out
module kb_code_receiver
  import alarm_pkg::*;
#(
  parameter int CODE_LEN    = 4,
  parameter int INTER_TO    = 50000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 100000
) (
  input logic CLK,
  input logic RST,
  kb_code_receiver_if.slave kb
);
  localparam int MAX_CNT = (INTER_TO > LOCK_CYCLES) ? INTER_TO : LOCK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(CODE_LEN + 1);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);
  localparam int KEY_W   = 2 * CODE_LEN;
  typedef enum logic [1:0] {IDLE, COLLECT, REPORT, LOCKOUT} rx_state_t;
  rx_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx;
  logic [KEY_W-1:0]  entry;
  logic [CNT_W-1:0]  cnt;
  logic [FAIL_W-1:0] fail, fail_rep;
  key_result_t       result, verdict;
  logic              sym_valid;
  logic [SYM_W-1:0]  sym;
  kb_strobe_sync u_sync (
    .clk       (CLK),
    .rst       (RST),
    .kb_recv   (kb.KB_RECV),
    .kb_in     (kb.KB_IN),
    .sym_valid (sym_valid),
    .sym       (sym)
  );
  always_comb begin
    verdict   = (entry == kb.KEY) ? KEY_OK : (entry == ~kb.KEY) ? KEY_OKNEG : KEY_ERROR;
    fail_rep  = (verdict == KEY_ERROR) ? fail + FAIL_W'(1) : '0;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = sym_valid ? COLLECT : IDLE;
      COLLECT: state_nxt = (sym_valid && idx == IDX_W'(CODE_LEN - 1)) ? REPORT :
                           (!sym_valid && cnt == CNT_W'(INTER_TO - 1)) ? IDLE : COLLECT;
      REPORT:  state_nxt = (fail_rep == FAIL_W'(MAX_FAIL)) ? LOCKOUT : sym_valid ? COLLECT : IDLE;
      LOCKOUT: state_nxt = (cnt == CNT_W'(LOCK_CYCLES - 1)) ? IDLE : LOCKOUT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      idx    <= '0;
      entry  <= '0;
      cnt    <= '0;
      fail   <= '0;
      result <= NO_KEY;
    end else begin
      state  <= state_nxt;
      result <= (state == REPORT) ? verdict : NO_KEY;
      // a symbol landing in REPORT starts the next entry unless we are about to lock out
      if (sym_valid && state != LOCKOUT && state_nxt != LOCKOUT) begin
        entry <= {entry[KEY_W-SYM_W-1:0], sym};
        idx   <= (state == COLLECT) ? idx + IDX_W'(1) : IDX_W'(1);
        cnt   <= '0;
      end else begin
        cnt <= ((state == COLLECT || state == LOCKOUT) && state_nxt == state) ? cnt + CNT_W'(1) : '0;
      end
      if (state == REPORT)
        fail <= fail_rep;
      else if (state == LOCKOUT && state_nxt == IDLE)
        fail <= '0;
    end
  end
  always_comb begin
    kb.RESULT = result;
    kb.BUSY   = (state == COLLECT);
    kb.LOCKED = (state == LOCKOUT);
  end
endmodule

// File: tb/tb_kb_code_receiver.sv
// tb_kb_code_receiver: directed self-checking bench for kb_code_receiver
module tb_kb_code_receiver;
  logic clk = 0;
  logic rst = 1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   pulses = 0;
  int   lock_cnt = 0;
  int   p0, l0;
  localparam logic [7:0] KEY_V = 8'b00_01_10_11;
  kb_code_receiver_if #(.CODE_LEN(4)) kb ();
  kb_code_receiver #(.CODE_LEN(4), .INTER_TO(20), .MAX_FAIL(3), .LOCK_CYCLES(40)) dut (
    .CLK (clk),
    .RST (rst),
    .kb  (kb)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (kb.RESULT != 2'd3) pulses++;
    if (kb.LOCKED == 1'b1) lock_cnt++;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_sym(input logic [1:0] s);
    kb.KB_IN = s;
    @(negedge clk);
    kb.KB_RECV = 1;
    @(negedge clk);
    @(negedge clk);
    kb.KB_RECV = 0;
    @(negedge clk);
  endtask
  task automatic send_last(input logic [1:0] s, input logic [1:0] exp, input logic lock_exp);
    send_sym(s);
    chk("busy_in_report", {7'd0, kb.BUSY}, 8'd0);
    chk("result_before", {6'd0, kb.RESULT}, 8'd3);
    @(negedge clk);
    chk("result_pulse", {6'd0, kb.RESULT}, {6'd0, exp});
    chk("locked_at_pulse", {7'd0, kb.LOCKED}, {7'd0, lock_exp});
    @(negedge clk);
    chk("result_after", {6'd0, kb.RESULT}, 8'd3);
  endtask
  task automatic enter_code(input logic [7:0] code, input logic [1:0] exp, input logic lock_exp);
    send_sym(code[7:6]);
    send_sym(code[5:4]);
    send_sym(code[3:2]);
    send_last(code[1:0], exp, lock_exp);
  endtask
  initial begin
    kb.KB_RECV = 0;
    kb.KB_IN   = 0;
    kb.KEY     = KEY_V;
    repeat (3) @(negedge clk);
    chk("reset_result", {6'd0, kb.RESULT}, 8'd3);
    chk("reset_busy", {7'd0, kb.BUSY}, 8'd0);
    chk("reset_locked", {7'd0, kb.LOCKED}, 8'd0);
    rst = 0;
    @(negedge clk);
    send_sym(2'd0);
    chk("busy_first", {7'd0, kb.BUSY}, 8'd1);
    send_sym(2'd1);
    send_sym(2'd2);
    chk("busy_third", {7'd0, kb.BUSY}, 8'd1);
    send_last(2'd3, 2'd0, 1'b0);
    enter_code(8'b11_10_01_00, 2'd1, 1'b0);
    enter_code(8'b00_01_10_10, 2'd2, 1'b0);
    enter_code(KEY_V, 2'd0, 1'b0);
    enter_code(8'b01_01_01_01, 2'd2, 1'b0);
    enter_code(8'b10_10_10_10, 2'd2, 1'b0);
    l0 = lock_cnt;
    enter_code(8'b11_11_11_11, 2'd2, 1'b1);
    p0 = pulses;
    enter_code(KEY_V, 2'd3, 1'b1);
    chk("lockout_no_pulse", pulses[7:0], p0[7:0]);
    chk("lockout_busy", {7'd0, kb.BUSY}, 8'd0);
    repeat (30) @(negedge clk);
    chk("lock_released", {7'd0, kb.LOCKED}, 8'd0);
    chk("lock_duration", lock_cnt[7:0] - l0[7:0], 8'd40);
    enter_code(KEY_V, 2'd0, 1'b0);
    send_sym(2'd0);
    send_sym(2'd1);
    p0 = pulses;
    repeat (18) @(negedge clk);
    chk("busy_before_timeout", {7'd0, kb.BUSY}, 8'd1);
    repeat (4) @(negedge clk);
    chk("busy_after_timeout", {7'd0, kb.BUSY}, 8'd0);
    chk("timeout_no_pulse", pulses[7:0], p0[7:0]);
    enter_code(KEY_V, 2'd0, 1'b0);
    send_sym(2'd0);
    send_sym(2'd1);
    send_sym(2'd2);
    chk("busy_before_rst", {7'd0, kb.BUSY}, 8'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_busy", {7'd0, kb.BUSY}, 8'd0);
    chk("rst_result", {6'd0, kb.RESULT}, 8'd3);
    p0 = pulses;
    repeat (5) @(negedge clk);
    chk("rst_no_pulse", pulses[7:0], p0[7:0]);
    kb.KB_IN = 2'd0;
    @(negedge clk);
    kb.KB_RECV = 1;
    repeat (10) @(negedge clk);
    chk("held_busy", {7'd0, kb.BUSY}, 8'd1);
    kb.KB_RECV = 0;
    repeat (2) @(negedge clk);
    send_sym(2'd1);
    send_sym(2'd2);
    send_last(2'd3, 2'd0, 1'b0);
    enter_code(8'b01_01_01_01, 2'd2, 1'b0);
    enter_code(KEY_V, 2'd0, 1'b0);
    enter_code(8'b01_01_01_01, 2'd2, 1'b0);
    enter_code(8'b10_10_10_10, 2'd2, 1'b0);
    repeat (3) @(negedge clk);
    chk("no_lockout_after_ok", {7'd0, kb.LOCKED}, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
